// File: rtl/booth_mult.sv
// booth_mult: sequential signed WIDTH x WIDTH multiplier, radix-2 Booth recoding.
// One iteration per clock; the full 2*WIDTH-bit product lands on hi/lo with a
// one-cycle mult_stop pulse.
//
// Ports:
//   clk        clock, rising edge
//   reset      synchronous, active-high reset
//   mult_init  start request level; held high until mult_stop is seen
//   value_a    multiplicand (signed), sampled only on the start edge
//   value_b    multiplier (signed), sampled only on the start edge
//   busy       high while iterating
//   mult_stop  one-cycle completion pulse
//   hi         product bits [2*WIDTH-1:WIDTH]
//   lo         product bits [WIDTH-1:0]
module booth_mult #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_init,
  input  logic [WIDTH-1:0] value_a,
  input  logic [WIDTH-1:0] value_b,
  output logic             busy,
  output logic             mult_stop,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  // One guard bit on A and M keeps A-M representable when M = -2^(WIDTH-1).
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH:0]   m_q, m_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             qm1_q, qm1_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             stop_q, stop_d;
  logic             busy_q, busy_d;
  logic [WIDTH:0]   sum;

  // Booth add/subtract selected by the current LSB pair {Q[0], q_m1}.
  always_comb begin
    sum = a_q;
    case ({q_q[0], qm1_q})
      2'b01:   sum = a_q + m_q;
      2'b10:   sum = a_q - m_q;
      default: sum = a_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    m_d     = m_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    stop_d  = stop_q;

    unique case (state_q)
      StIdle: begin
        stop_d = 1'b0;
        if (mult_init) begin
          m_d     = {value_a[WIDTH-1], value_a};
          a_d     = '0;
          q_d     = value_b;
          qm1_d   = 1'b0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        // Arithmetic right shift of {A, Q, q_m1}, replicating A's sign bit.
        a_d   = {sum[WIDTH], sum[WIDTH:1]};
        q_d   = {sum[0], q_q[WIDTH-1:1]};
        qm1_d = q_q[0];
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StDone;
          hi_d    = a_d[WIDTH-1:0];
          lo_d    = q_d;
          stop_d  = 1'b1;
        end
      end
      StDone: begin
        stop_d = 1'b0;
        // A held init must not retrigger; wait for it to drop first.
        if (!mult_init) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        stop_d  = 1'b0;
      end
    endcase

    busy_d = (state_d == StRun);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      a_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      stop_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      stop_q  <= stop_d;
      busy_q  <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign mult_stop = stop_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_booth_mult.sv
// Self-checking bench for booth_mult: a cycle-level behavioural model computes
// expected outputs from plain signed multiplication; a compare process checks
// every cycle, and directed cases pin known products and latencies.
module tb_booth_mult;

  localparam int unsigned W = 32;

  logic          clk;
  logic          reset;
  logic          mult_init;
  logic [W-1:0]  value_a;
  logic [W-1:0]  value_b;
  logic          busy;
  logic          mult_stop;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;

  int checks = 0;
  int errors = 0;

  booth_mult #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .mult_init (mult_init),
    .value_a   (value_a),
    .value_b   (value_b),
    .busy      (busy),
    .mult_stop (mult_stop),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 waiting, 1 multiplying, 2 finished.
  int           m_phase = 0;
  int           m_left  = 0;
  logic [W-1:0] m_a, m_b;
  logic [W-1:0] e_hi = '0, e_lo = '0;
  logic         e_busy = 1'b0, e_stop = 1'b0;
  bit           m_ready = 1'b0;

  always @(posedge clk) begin
    longint prod;
    if (reset) begin
      m_phase = 0;
      e_hi = '0; e_lo = '0; e_busy = 1'b0; e_stop = 1'b0;
      m_ready = 1'b1;
    end else if (m_ready) begin
      case (m_phase)
        0: begin
          e_stop = 1'b0;
          if (mult_init) begin
            m_a = value_a; m_b = value_b;
            m_left = W; m_phase = 1; e_busy = 1'b1;
          end
        end
        1: begin
          m_left--;
          if (m_left == 0) begin
            prod = longint'($signed(m_a)) * longint'($signed(m_b));
            e_hi = prod[63:32]; e_lo = prod[31:0];
            e_stop = 1'b1; e_busy = 1'b0; m_phase = 2;
          end
        end
        default: begin
          e_stop = 1'b0;
          if (!mult_init) m_phase = 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_ready) begin
      chk("busy", 64'(busy), 64'(e_busy));
      chk("mult_stop", 64'(mult_stop), 64'(e_stop));
      chk("hi", 64'(hi), 64'(e_hi));
      chk("lo", 64'(lo), 64'(e_lo));
    end
  end

  // Called at a negedge; sets up operands so the next edge samples them.
  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b);
    value_a   = a;
    value_b   = b;
    mult_init = 1'b1;
  endtask

  // Counts negedges from the start until mult_stop, bounded.
  task automatic wait_done(input int change_at, input int drop_at,
                           output int cyc, output int busy_cyc);
    cyc = 0;
    busy_cyc = 0;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_cyc++;
      if (mult_stop) break;
      if (cyc == change_at) begin
        value_a = 32'h1234;
        value_b = 32'h5678;
      end
      if (cyc == drop_at) mult_init = 1'b0;
    end
    chk("stop_seen", 64'(mult_stop), 64'd1);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h0;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int cyc, bcyc, stops;
    logic [W-1:0] h0, l0;
    reset = 1'b1; mult_init = 1'b0; value_a = '0; value_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_stop", 64'(mult_stop), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // 3 * 5 with latency and busy-length pins.
    start(32'd3, 32'd5);
    wait_done(0, 0, cyc, bcyc);
    chk("lat_3x5", 64'(cyc), 64'd33);
    chk("busy_len", 64'(bcyc), 64'd32);
    chk("p_3x5", {hi, lo}, 64'h0000_0000_0000_000F);
    @(negedge clk);
    chk("stop_pulse", 64'(mult_stop), 64'd0);
    mult_init = 1'b0; @(negedge clk);

    start(32'hFFFF_FFF9, 32'd6);
    wait_done(0, 0, cyc, bcyc);
    chk("p_m7x6", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFD6);
    mult_init = 1'b0; @(negedge clk);

    start(32'h8000_0000, 32'h8000_0000);
    wait_done(0, 0, cyc, bcyc);
    chk("p_min_min", {hi, lo}, 64'h4000_0000_0000_0000);
    mult_init = 1'b0; @(negedge clk);

    start(32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(0, 0, cyc, bcyc);
    chk("p_min_m1", {hi, lo}, 64'h0000_0000_8000_0000);
    mult_init = 1'b0; @(negedge clk);

    // Operand change mid-run must be ignored; then init held past completion.
    start(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(6, 0, cyc, bcyc);
    chk("p_m1_m1", {hi, lo}, 64'h0000_0000_0000_0001);
    h0 = hi; l0 = lo; stops = 0;
    repeat (10) begin
      @(negedge clk);
      if (mult_stop) stops++;
    end
    chk("held_no_restart", 64'(stops), 64'd0);
    chk("held_stable", {hi, lo}, {h0, l0});
    mult_init = 1'b0; @(negedge clk);
    start(32'd2, 32'hFFFF_FFFD);
    wait_done(0, 0, cyc, bcyc);
    chk("p_2_m3", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    mult_init = 1'b0; @(negedge clk);

    // Reset at RUN cycle 10 with init still high; reset wins, then restart.
    start(32'd100, 32'd100);
    repeat (11) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_hi", 64'(hi), 64'd0);
    chk("mid_rst_lo", 64'(lo), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_stop", 64'(mult_stop), 64'd0);
    reset = 1'b0;
    wait_done(0, 0, cyc, bcyc);
    chk("lat_restart", 64'(cyc), 64'd33);
    chk("p_100x100", {hi, lo}, 64'h0000_0000_0000_2710);
    mult_init = 1'b0; @(negedge clk);

    // Randomized operations, some with init dropped mid-run.
    for (int i = 0; i < 40; i++) begin
      start(pick(), pick());
      wait_done(0, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : 0, cyc, bcyc);
      chk("lat_rand", 64'(cyc), 64'd33);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      mult_init = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/booth_mult.md
Name: booth_mult

Overview:
- Sequential signed 32x32 multiplier using radix-2 Booth recoding.
- It is the companion of the restoring divider on the ALU side of the datapath.
- The control unit uses the same handshake for both: init level in, one-cycle stop pulse out, result on hi/lo.
- Produces the full 64-bit two's-complement product for MULT: hi = upper 32 bits, lo = lower 32 bits.

Parameters:
WIDTH, 32, operand width; product is 2*WIDTH bits.

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
mult_init  input  1  start request level from control unit; held high until mult_stop seen
value_a  input  WIDTH  multiplicand, signed
value_b  input  WIDTH  multiplier, signed
busy  output  1  high while in RUN
mult_stop  output  1  one-cycle completion pulse
hi  output  WIDTH  product bits [2*WIDTH-1:WIDTH]
lo  output  WIDTH  product bits [WIDTH-1:0]

Behaviour:
- Reset, applied at any time including mid-run:
  - state=IDLE; hi=0, lo=0, mult_stop=0, busy=0.
  - Internal accumulator, multiplier register, q_m1 and counter are cleared.
- All outputs are registered.
- State IDLE:
  - If mult_init=1, latch M=value_a as a sign-extended WIDTH+1 bit value.
  - Load A=0 (WIDTH+1 bits), Q=value_b, q_m1=0, cnt=0; go to RUN.
  - Operands are sampled only on this edge; later changes on value_a/value_b are ignored.
- State RUN, once per cycle, WIDTH iterations:
  - {Q[0],q_m1}=01: A=A+M. 10: A=A-M. 00 or 11: A unchanged.
  - Then arithmetic right shift of {A,Q,q_m1} by one; A's sign bit is replicated.
  - cnt increments each iteration.
  - On the iteration with cnt=WIDTH-1: go to DONE, load hi=A[WIDTH-1:0] and lo=Q from the post-shift values, set mult_stop=1.
- The WIDTH+1 bit accumulator guarantees correct results for M=-2^(WIDTH-1); no overflow case exists.
- Latency: mult_init sampled in IDLE at edge k; iterations on edges k+1..k+WIDTH. mult_stop and the new hi/lo are visible in the cycle after edge k+WIDTH (33 cycles from start for WIDTH=32).
- State DONE:
  - mult_stop returns to 0 on the next edge (exactly one cycle high).
  - Block stays in DONE while mult_init=1, so a held init never restarts it.
  - Returns to IDLE on the first edge with mult_init=0.
  - A new operation needs init low for at least one cycle, then high again.
- hi/lo hold the last completed product until the next completion or reset. They are not disturbed during RUN.
- busy=1 exactly in RUN.
- mult_init deasserted during RUN does not abort; the operation completes and the FSM then passes through DONE to IDLE.
- Reset and mult_init high on the same edge: reset wins; next start needs init sampled in IDLE afterwards.
- No error outputs; every operand pair is legal.

Test Plan:
- a=3, b=5, init held -> mult_stop single pulse 33 cycles after init sampled; hi=0x00000000, lo=0x0000000F; busy high for 32 cycles.
- a=-7 (0xFFFFFFF9), b=6 -> hi=0xFFFFFFFF, lo=0xFFFFFFD6.
- a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0x00000000. Also a=0x80000000, b=0xFFFFFFFF -> hi=0x00000000, lo=0x80000000.
- a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0, lo=1. Change value_a/value_b to 0x1234/0x5678 at cycle 5 of RUN -> result unchanged.
- Keep init high 10 cycles past mult_stop -> no second pulse, hi/lo stable. Drop init for 1 cycle, raise with a=2, b=-3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- Start a=100, b=100, assert reset at RUN cycle 10 -> next cycle hi=lo=0, busy=0, mult_stop=0. Restart a=100, b=100 -> lo=0x00002710, hi=0.
